// File: rtl/byte_lane_dly_pkg.sv
// Shared constants, FSM state type and address-map helpers for the byte-lane delay loader.
package byte_lane_dly_pkg;
  localparam int DLY_ADDR_W  = 5;
  localparam int DLY_DATA_W  = 8;
  localparam int SCAN_LEN    = 32;
  localparam int IN_DLY_BASE = 16;

  typedef enum logic [1:0] {IDLE, SCAN, SET, DONE} dly_state_e;

  function automatic logic [DLY_ADDR_W-1:0] dqs_out_addr(input int num_dq);
    return DLY_ADDR_W'(num_dq);
  endfunction

  function automatic logic [DLY_ADDR_W-1:0] dm_addr(input int num_dq);
    return DLY_ADDR_W'(num_dq + 1);
  endfunction

  function automatic logic [DLY_ADDR_W-1:0] dqs_in_addr(input int num_dq);
    return DLY_ADDR_W'(IN_DLY_BASE + num_dq);
  endfunction

  // Low half ends at DM (DQ, DQS, DM); the high half has no DM, so it ends at DQS.
  function automatic logic addr_valid(input logic [DLY_ADDR_W-1:0] addr, input int num_dq);
    int a;
    a = int'(addr);
    if (a < IN_DLY_BASE) return a <= int'(dm_addr(num_dq));
    return a <= int'(dqs_in_addr(num_dq));
  endfunction
endpackage

// File: rtl/dly_shadow_ram.sv
// 32x8 shadow table of target tap values: host write port, registered read-back port,
// combinational scan port. Dirty tracking exists only with BYTE_LANE_DLY_DIRTY_ONLY_EN.
module dly_shadow_ram
  import byte_lane_dly_pkg::*;
#(
  parameter logic [DLY_DATA_W-1:0] RST_TAP = '0
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DLY_ADDR_W-1:0] wr_addr,
  input  logic [DLY_DATA_W-1:0] wr_data,
  input  logic [DLY_ADDR_W-1:0] rd_addr,
  output logic [DLY_DATA_W-1:0] rd_data,
  input  logic [DLY_ADDR_W-1:0] scan_addr,
  output logic [DLY_DATA_W-1:0] scan_data,
  output logic                  scan_dirty,
  input  logic                  scan_clr
);
  logic [DLY_DATA_W-1:0] mem [SCAN_LEN];

  // Read-back samples the pre-write contents, so a same-cycle write/read returns the old value.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      for (int i = 0; i < SCAN_LEN; i++) mem[i] <= RST_TAP;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end

  assign scan_data = mem[scan_addr];

`ifdef BYTE_LANE_DLY_DIRTY_ONLY_EN
  logic [SCAN_LEN-1:0] dirty;

  // The write update comes last so a write landing on the entry being loaded keeps it dirty.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      dirty <= '1;
    end else begin
      if (scan_clr) dirty[scan_addr] <= 1'b0;
      if (wr_en)    dirty[wr_addr]   <= 1'b1;
    end
  end

  assign scan_dirty = dirty[scan_addr];
`else
  logic unused_scan_clr;
  assign unused_scan_clr = scan_clr;
  assign scan_dirty      = 1'b1;
`endif
endmodule

// File: rtl/byte_lane_dly_loader.sv
// Scans the shadow table, loads each valid tap value into the byte lane, then pulses set.
// Optional BYTE_LANE_DLY_DIRTY_ONLY_EN restricts loads to entries written since their last load.
module byte_lane_dly_loader
  import byte_lane_dly_pkg::*;
#(
  parameter int                    NUM_DQ  = 8,
  parameter logic [DLY_DATA_W-1:0] RST_TAP = '0
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DLY_ADDR_W-1:0] wr_addr,
  input  logic [DLY_DATA_W-1:0] wr_data,
  input  logic [DLY_ADDR_W-1:0] rd_addr,
  output logic [DLY_DATA_W-1:0] rd_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DLY_DATA_W-1:0] dly_data,
  output logic [DLY_ADDR_W-1:0] dly_addr,
  output logic                  ld_delay,
  output logic                  set,
  output dly_state_e            dbg_state
);
  localparam logic [DLY_ADDR_W-1:0] LAST_ADDR = DLY_ADDR_W'(SCAN_LEN - 1);

  // start is a one-cycle request honoured only in IDLE; busy covers scan+set, done pulses once after.
  dly_state_e            state, state_nxt;
  logic [DLY_ADDR_W-1:0] cnt, cnt_nxt;
  logic                  busy_d, done_d, set_d, ld_d;
  logic [DLY_ADDR_W-1:0] addr_d;
  logic [DLY_DATA_W-1:0] data_d, scan_data;
  logic                  scan_dirty;

  dly_shadow_ram #(.RST_TAP(RST_TAP)) u_shadow (
    .clk_div    (clk_div),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .scan_addr  (cnt_nxt),
    .scan_data  (scan_data),
    .scan_dirty (scan_dirty),
    .scan_clr   (ld_d)
  );

  always_ff @(posedge clk_div) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
      SCAN: begin
        cnt_nxt = cnt + DLY_ADDR_W'(1);
        if (cnt == LAST_ADDR) state_nxt = SET;
      end
      SET:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with no extra latency.
  always_comb begin
    busy_d = (state_nxt == SCAN) || (state_nxt == SET);
    set_d  = (state_nxt == SET);
    done_d = (state_nxt == DONE);
    ld_d   = 1'b0;
    addr_d = dly_addr;
    data_d = dly_data;
    if (state_nxt == SCAN) begin
      addr_d = cnt_nxt;
      data_d = scan_data;
      ld_d   = addr_valid(cnt_nxt, NUM_DQ) && scan_dirty;
    end
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      set      <= 1'b0;
      ld_delay <= 1'b0;
      dly_addr <= '0;
      dly_data <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      set      <= set_d;
      ld_delay <= ld_d;
      dly_addr <= addr_d;
      dly_data <= data_d;
    end
  end

  assign dbg_state = state;
endmodule
